// File: rtl/axi_slice_fifo.sv
// axi_slice_fifo: DEPTH-entry elastic buffer with a registered valid/ready
// handshake on both sides. valid_o, data_o, ready_o, count_o and
// almost_full_o all come straight from flops, so no combinational path
// crosses the block in either direction.
//
// Handshake: a word moves on a rising edge where valid and ready are both
// high (push = valid_i && ready_o, pop = valid_o && ready_i). The producer
// may drop valid at any time; the consumer sees data_o/valid_o held stable
// while valid_o && !ready_i.
//
// Optional feature: define AXI_SLICE_FIFO_LAST_EN to add last_i/last_o
// sideband and the pkt_cnt_o counter of stored words flagged last.
module axi_slice_fifo #(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       aclk_i,
  input  logic                       aresetn_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [DWIDTH-1:0]          data_i,
`ifdef AXI_SLICE_FIFO_LAST_EN
  input  logic                       last_i,
  output logic                       last_o,
  output logic [$clog2(DEPTH+1)-1:0] pkt_cnt_o,
`endif
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [DWIDTH-1:0]          data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Storage holds every live word; data_o is a registered copy of the head
  // entry so the downstream side sees a pure flop output.
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_inc;
  logic [CW-1:0]     count_next;
  logic              push;
  logic              pop;
  logic              load_head;
  logic              head_from_mem;

  assign push       = valid_i && ready_o;
  assign pop        = valid_o && ready_i;
  assign rd_ptr_inc = rd_ptr + PW'(1);

  // Next occupancy; flush overrides any push or pop on the same edge.
  always_comb begin
    count_next = count_o;
    if (flush_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_o + CW'(1);
        2'b01:   count_next = count_o - CW'(1);
        default: count_next = count_o;
      endcase
    end
  end

  // Decide whether the output register takes a new head word, and from where:
  // the next stored entry when one exists, otherwise the incoming word.
  always_comb begin
    load_head     = 1'b0;
    head_from_mem = 1'b0;
    if (!flush_i) begin
      if (pop) begin
        if (count_o > CW'(1)) begin
          load_head     = 1'b1;
          head_from_mem = 1'b1;
        end else if (push) begin
          load_head = 1'b1;
        end
      end else if (push && (count_o == '0)) begin
        load_head = 1'b1;
      end
    end
  end

  // Payload storage write; contents are don't-care until pushed.
  always_ff @(posedge aclk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy, flags and the output register.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_o       <= '0;
      ready_o       <= 1'b0;
      valid_o       <= 1'b0;
      almost_full_o <= 1'b0;
      data_o        <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr_inc;
      end
      count_o       <= count_next;
      ready_o       <= (count_next < CW'(DEPTH));
      valid_o       <= (count_next > '0);
      almost_full_o <= (count_next >= CW'(AF_THRESH));
      if (load_head) begin
        data_o <= head_from_mem ? mem[rd_ptr_inc] : data_i;
      end
    end
  end

`ifdef AXI_SLICE_FIFO_LAST_EN
  logic          last_mem [DEPTH];
  logic [CW-1:0] pkt_cnt_next;

  // Packet counter tracks stored words flagged last.
  always_comb begin
    pkt_cnt_next = pkt_cnt_o;
    if (flush_i) begin
      pkt_cnt_next = '0;
    end else begin
      case ({push && last_i, pop && last_o})
        2'b10:   pkt_cnt_next = pkt_cnt_o + CW'(1);
        2'b01:   pkt_cnt_next = pkt_cnt_o - CW'(1);
        default: pkt_cnt_next = pkt_cnt_o;
      endcase
    end
  end

  // Sideband storage write, shadowing the payload storage.
  always_ff @(posedge aclk_i) begin
    if (push && !flush_i) begin
      last_mem[wr_ptr] <= last_i;
    end
  end

  // Sideband output register and packet counter.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      last_o    <= 1'b0;
      pkt_cnt_o <= '0;
    end else begin
      pkt_cnt_o <= pkt_cnt_next;
      if (load_head) begin
        last_o <= head_from_mem ? last_mem[rd_ptr_inc] : last_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_slice_fifo.sv
// Testbench for axi_slice_fifo: table-driven fill/drain vectors, hand-written
// corner sequences and a random stress run, all checked against a queue model.
module tb_axi_slice_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk_i    = 1'b0;
  logic          aresetn_i = 1'b0;
  logic          flush_i   = 1'b0;
  logic          valid_i   = 1'b0;
  logic          ready_i   = 1'b0;
  logic [DW-1:0] data_i    = '0;
  logic          ready_o;
  logic          valid_o;
  logic          almost_full_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] count_o;
`ifdef AXI_SLICE_FIFO_LAST_EN
  logic          last_i = 1'b0;
  logic          last_o;
  logic [CW-1:0] pkt_cnt_o;
`endif

  axi_slice_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .aclk_i        (aclk_i),
    .aresetn_i     (aresetn_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
`ifdef AXI_SLICE_FIFO_LAST_EN
    .last_i        (last_i),
    .last_o        (last_o),
    .pkt_cnt_o     (pkt_cnt_o),
`endif
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .ready_i       (ready_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  // Clock and watchdog
  always #5 aclk_i = ~aclk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  bit            lq[$];
  logic          m_ready;
  logic [DW-1:0] m_data;
  bit            m_last;
  int            n_cmp  = 0;
  int            n_err  = 0;
  int            n_pops = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic [CW-1:0] cnt;
    logic          vo;
    logic          ro;
    logic          af;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int pk;
    chk("count_o", 32'(count_o), 32'(exp_q.size()));
    chk("valid_o", 32'(valid_o), 32'(exp_q.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(m_ready));
    chk("almost_full_o", 32'(almost_full_o), 32'(exp_q.size() >= AF));
    chk("data_o", 32'(data_o), 32'(m_data));
    pk = 0;
    foreach (lq[i]) if (lq[i]) pk++;
`ifdef AXI_SLICE_FIFO_LAST_EN
    chk("last_o", 32'(last_o), 32'(m_last));
    chk("pkt_cnt_o", 32'(pkt_cnt_o), 32'(pk));
`endif
  endtask

  // Driver: apply inputs at the falling edge, update the model at the rising
  // edge, check at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic l);
    logic [DW-1:0] dummy_d;
    bit            dummy_l;
    bit            do_pop;
    bit            do_push;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
`ifdef AXI_SLICE_FIFO_LAST_EN
    last_i  = l;
`endif
    @(posedge aclk_i);
    if (f) begin
      exp_q.delete();
      lq.delete();
    end else begin
      do_pop  = (exp_q.size() > 0) && r;
      do_push = v && m_ready;
      if (do_pop) begin
        dummy_d = exp_q.pop_front();
        dummy_l = lq.pop_front();
        n_pops++;
      end
      if (do_push) begin
        exp_q.push_back(d);
        lq.push_back(l);
      end
      if (exp_q.size() > 0) begin
        m_data = exp_q[0];
        m_last = lq[0];
      end
    end
    m_ready = (exp_q.size() < DEPTH);
    @(negedge aclk_i);
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    lq.delete();
    m_ready = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk_i);
    aresetn_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; data_i = '0;
    model_reset();
    repeat (3) begin
      @(negedge aclk_i);
      check_outputs();
    end
    aresetn_i = 1'b1;
    check_outputs();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ready_after_reset", 32'(ready_o), 32'd1);
  endtask

  // Main sequence
  initial begin
    int base;
    model_reset();

    tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h33};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'h44};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h44};

    do_reset();

    // Fill and drain from the vector table
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d].count_o", i), 32'(count_o), 32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d].valid_o", i), 32'(valid_o), 32'(tbl[i].vo));
      chk($sformatf("tbl[%0d].ready_o", i), 32'(ready_o), 32'(tbl[i].ro));
      chk($sformatf("tbl[%0d].almost_full_o", i), 32'(almost_full_o), 32'(tbl[i].af));
      chk($sformatf("tbl[%0d].data_o", i), 32'(data_o), 32'(tbl[i].dout));
    end

    // Streaming: one word per clock, occupancy steady at 1
    base = n_pops;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_count", 32'(count_o), 32'd1);
      if (i > 0) chk("stream_gapless_pops", 32'(n_pops - base), 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_total_pops", 32'(n_pops - base), 32'd20);

    // Simultaneous valid/ready at full: pop only, then push+pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count_o), 32'(DEPTH));
    step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
    chk("full_pop_no_push", 32'(count_o), 32'(DEPTH - 1));
    step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
    chk("full_next_push_pop", 32'(count_o), 32'(DEPTH - 1));
    chk("full_head_a2", 32'(data_o), 32'h0A2);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with push and pop requested on the same edge
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_data_hold", 32'(data_o), 32'h0C0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_word_dropped", 32'(valid_o), 32'd0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("after_flush_push", 32'(data_o), 32'h05A);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset asserted mid-transfer clears everything immediately
    step(1'b1, 8'h61, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    #2;
    aresetn_i = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge aclk_i);
    check_outputs();
    aresetn_i = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Random stress against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom()), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("stress_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slice_fifo.md
Name: axi_slice_fifo

Overview:
- Parametrised successor to the single-entry valid/ready register slice: a DEPTH-entry elastic buffer with the same upstream/downstream handshake.
- valid_o, data_o and ready_o are all driven straight from flops, so the block breaks every combinational path in both directions.
- Sustains one transfer per clock.
- Adds occupancy, almost-full and synchronous flush, which the single-entry slice lacks.
- Dropped between chained pipeline stages in the AXI-stream datapath.

Parameters:
- DWIDTH, 8, payload width in bits.
- DEPTH, 4, number of storage entries including the output register; power of 2, >= 2.
- AF_THRESH, DEPTH-1, almost_full_o asserts when occupancy >= AF_THRESH; range 1..DEPTH.

Ports:
- aclk_i  input  1  clock, rising edge.
- aresetn_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all stored words.
- valid_i  input  1  upstream valid.
- data_i  input  DWIDTH  upstream payload.
- ready_o  output  1  upstream ready; registered.
- valid_o  output  1  downstream valid; registered.
- data_o  output  DWIDTH  downstream payload; registered.
- ready_i  input  1  downstream ready.
- count_o  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH; registered.
- almost_full_o  output  1  registered (count_o >= AF_THRESH).

Behaviour:
- Reset (aresetn_i low, asynchronous): valid_o=0, data_o=0, ready_o=0, count_o=0, almost_full_o=0, read/write pointers=0.
- First rising edge after reset release: ready_o goes to 1. Reset may assert mid-transfer; all state clears immediately and in-flight words are lost.
- Handshakes:
  - push = valid_i && ready_o; pop = valid_o && ready_i, both sampled at the rising edge.
  - Push and pop in the same edge are both legal at any occupancy 1..DEPTH-1, and at DEPTH when a pop occurs (ready_o is already low then, so no push).
- Occupancy update: count_next = count + push - pop. Wrap-free, never exceeds DEPTH, never goes below 0.
- ready_o register <= (count_next < DEPTH).
  - Push that fills the buffer: ready_o is low from that edge.
  - Pop from full: ready_o is high from that edge. No bubble cycle.
- almost_full_o register <= (count_next >= AF_THRESH).
- Latency: a word pushed at edge k into an empty buffer, or one whose only entry pops at edge k, appears on data_o with valid_o=1 right after edge k. Minimum latency is 1 cycle.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Output hold: while valid_o && !ready_i, data_o and valid_o hold stable.
- valid_o register <= (count_next > 0). data_o always shows the oldest stored word.
- Upstream protocol: the block does not require valid_i to hold once raised. It accepts a word only on push.
- flush_i=1 at an edge:
  - count=0, valid_o=0, ready_o=1, almost_full_o=0, pointers reset; data_o keeps its value.
  - Any push or pop in the same edge is discarded and not counted. Flush has priority over both.
- Throughput: continuous valid_i=1, ready_i=1 gives one word per clock after the first, with count_o steady at 1.

Optional Feature:
- Macro AXI_SLICE_FIFO_LAST_EN.
- Defined:
  - Adds ports last_i (input 1) and last_o (output 1), stored alongside data and reset to 0.
  - Adds pkt_cnt_o (output, $clog2(DEPTH+1)): number of stored words with last=1. It increments on a push with last_i=1, decrements on a pop with last_o=1, and clears on flush or reset.
- Undefined: those ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: aresetn_i=0 for 3 cycles, then release -> all outputs 0 during reset; ready_o=1 on the first edge after release; count_o=0.
- Fill and drain, DEPTH=4, ready_i=0, push 0x11,0x22,0x33,0x44 on consecutive edges -> count_o 1,2,3,4; almost_full_o rises with count_o=3; ready_o=0 after the 4th push. Then ready_i=1 -> data_o 0x11,0x22,0x33,0x44 on consecutive cycles; ready_o=1 after the first pop.
- Streaming: valid_i=ready_i=1 for 20 cycles with incrementing data 0x00..0x13 -> 20 pops, no gaps after the first, order preserved, count_o=1 throughout.
- Simultaneous at full: count=4, ready_i=1, valid_i=1 -> the pop occurs, no push that edge; push accepted at the next edge; count_o goes 4->3->3.
- Flush: count=3, assert flush_i with valid_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0, ready_o=1; the pushed word never appears on data_o.
- Random stress: random valid_i and ready_i, 10000 cycles, compared against a scoreboard -> no loss, duplication or reordering; data_o stable while stalled. With AXI_SLICE_FIFO_LAST_EN, pkt_cnt_o matches the model.
